// File: rtl/bin_to_bcd_converter_if.sv
// bin_to_bcd_converter_if: request/result bundle between a binary source and the BCD converter
interface bin_to_bcd_converter_if #(
    parameter int IN_WIDTH = 27,
    parameter int DIGITS = 8
);
    logic [IN_WIDTH-1:0] bin_in;
    logic valid_in;
    logic ready_out;
    logic [4*DIGITS-1:0] bcd_out;
    logic valid_out;
    logic overflow_out;
    modport master (
        output bin_in, valid_in,
        input  ready_out, bcd_out, valid_out, overflow_out
    );
    modport slave (
        input  bin_in, valid_in,
        output ready_out, bcd_out, valid_out, overflow_out
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: iterative double-dabble, one bit per cycle; BCD_OVERFLOW_SAT_EN enables overflow flag and EEEE saturation
module bin_to_bcd_converter #(
    parameter int IN_WIDTH = 27,
    parameter int DIGITS = 8
) (
    input logic clk_in,
    input logic rst_in,
    bin_to_bcd_converter_if.slave bus
);
    localparam int BW = 4*DIGITS;
    localparam int CNTW = $clog2(IN_WIDTH+1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [IN_WIDTH-1:0] bin_r;
    logic [BW-1:0] bcd_r, adj, nxt, bcd_q;
    logic [CNTW-1:0] cnt;
    logic valid_q;
    assign bus.ready_out = state == IDLE;
    assign bus.bcd_out = bcd_q;
    assign bus.valid_out = valid_q;
    assign nxt = {adj[BW-2:0], bin_r[IN_WIDTH-1]};
`ifdef BCD_OVERFLOW_SAT_EN
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p*10;
        return p;
    endfunction
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int CW = IN_WIDTH > $clog2(MAX_VAL+1) ? IN_WIDTH : $clog2(MAX_VAL+1);
    logic ovf_r, ovf_q, in_ovf;
    assign in_ovf = CW'(bus.bin_in) > CW'(MAX_VAL);
    assign bus.overflow_out = ovf_q;
`else
    assign bus.overflow_out = 1'b0;
`endif
    // add-3 correction on every working digit that would overflow when doubled
    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = bcd_r[4*i+:4] >= 4'd5 ? bcd_r[4*i+:4] + 4'd3 : bcd_r[4*i+:4];
    end
    // control FSM; result and pulse are registered on the last shift so they appear in DONE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            bin_r <= '0;
            bcd_r <= '0;
            cnt <= '0;
            bcd_q <= '0;
            valid_q <= 1'b0;
`ifdef BCD_OVERFLOW_SAT_EN
            ovf_r <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.valid_in) begin
                    bin_r <= bus.bin_in;
                    bcd_r <= '0;
                    cnt <= CNTW'(IN_WIDTH);
                    state <= SHIFT;
`ifdef BCD_OVERFLOW_SAT_EN
                    ovf_r <= in_ovf;
`endif
                end
                SHIFT: begin
                    bcd_r <= nxt;
                    bin_r <= {bin_r[IN_WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNTW'(1)) begin
                        state <= DONE;
                        valid_q <= 1'b1;
`ifdef BCD_OVERFLOW_SAT_EN
                        bcd_q <= ovf_r ? {DIGITS{4'hE}} : nxt;
                        ovf_q <= ovf_r;
`else
                        bcd_q <= nxt;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: table, random and handshake-corner checks against an arithmetic BCD model
module tb_bin_to_bcd_converter;
    logic clk_in = 1'b0;
    logic rst_in;
    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bin_to_bcd_converter_if #(.IN_WIDTH(27), .DIGITS(8)) bus ();
    bin_to_bcd_converter #(.IN_WIDTH(27), .DIGITS(8)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus.slave)
    );
    always #5 clk_in = ~clk_in;
    // count every valid_out pulse seen at a clock edge
    always @(posedge clk_in) if (bus.valid_out === 1'b1) pulses <= pulses + 1;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_bcd(input longint unsigned v);
        longint unsigned x;
        logic [31:0] r;
`ifdef BCD_OVERFLOW_SAT_EN
        if (v > 64'd99999999) return 32'hEEEEEEEE;
`endif
        x = v % 64'd100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint unsigned v);
`ifdef BCD_OVERFLOW_SAT_EN
        return v > 64'd99999999;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // wait for valid_out starting at cycle number start; reports the cycle it rose in
    task automatic wait_valid(input string name, input int start, output int n);
        logic rdy_seen;
        rdy_seen = 1'b0;
        n = start;
        while (bus.valid_out !== 1'b1 && n < 100) begin
            if (bus.ready_out !== 1'b0) rdy_seen = 1'b1;
            tick();
            n++;
        end
        check({name, "_busy_ready"}, rdy_seen, 1'b0);
        check({name, "_done_ready"}, bus.ready_out, 1'b0);
    endtask

    task automatic convert(input logic [26:0] v, input string name, input logic [31:0] exp_bcd, input logic exp_ovf);
        int n, p0;
        n = 0;
        while (bus.ready_out !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_idle_ready"}, bus.ready_out, 1'b1);
        p0 = pulses;
        bus.bin_in = v;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        bus.bin_in = 27'($urandom);
        wait_valid(name, 1, n);
        check({name, "_latency"}, n, 28);
        check({name, "_bcd"}, bus.bcd_out, exp_bcd);
        check({name, "_ovf"}, bus.overflow_out, exp_ovf);
        tick();
        check({name, "_pulse_end"}, bus.valid_out, 1'b0);
        check({name, "_ready_back"}, bus.ready_out, 1'b1);
        check({name, "_pulses"}, pulses - p0, 1);
        check({name, "_hold"}, bus.bcd_out, exp_bcd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n, p0;
        logic [26:0] v;
        tbl[0] = '{27'd12345678, 32'h12345678, 1'b0};
        tbl[1] = '{27'd0, 32'h00000000, 1'b0};
        tbl[2] = '{27'd9, 32'h00000009, 1'b0};
        tbl[3] = '{27'd10, 32'h00000010, 1'b0};
        tbl[4] = '{27'd99999999, 32'h99999999, 1'b0};
`ifdef BCD_OVERFLOW_SAT_EN
        tbl[5] = '{27'd100000000, 32'hEEEEEEEE, 1'b1};
        tbl[6] = '{27'd134217727, 32'hEEEEEEEE, 1'b1};
`else
        tbl[5] = '{27'd100000000, 32'h00000000, 1'b0};
        tbl[6] = '{27'd134217727, 32'h34217727, 1'b0};
`endif
        tbl[7] = '{27'd5, 32'h00000005, 1'b0};
        rst_in = 1'b1;
        bus.valid_in = 1'b1;
        bus.bin_in = 27'd99;
        repeat (3) tick();
        bus.valid_in = 1'b0;
        rst_in = 1'b0;
        check("reset_ready", bus.ready_out, 1'b1);
        check("reset_valid", bus.valid_out, 1'b0);
        check("reset_bcd", bus.bcd_out, 32'h0);
        check("reset_ovf", bus.overflow_out, 1'b0);
        for (int i = 0; i < 8; i++)
            convert(tbl[i].bin, $sformatf("vec%0d", i), tbl[i].bcd, tbl[i].ovf);
        // back-to-back with valid_in held high
        p0 = pulses;
        bus.bin_in = 27'd0;
        bus.valid_in = 1'b1;
        tick();
        bus.bin_in = 27'd99999999;
        wait_valid("b2b_a", 1, n);
        check("b2b_a_latency", n, 28);
        check("b2b_a_bcd", bus.bcd_out, 32'h0);
        tick();
        check("b2b_idle_ready", bus.ready_out, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        wait_valid("b2b_b", 1, n);
        check("b2b_b_latency", n, 28);
        check("b2b_b_bcd", bus.bcd_out, 32'h99999999);
        tick();
        check("b2b_pulses", pulses - p0, 2);
        // request while busy is ignored
        p0 = pulses;
        bus.bin_in = 27'd42;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        repeat (5) tick();
        bus.bin_in = 27'd7;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        wait_valid("busy", 7, n);
        check("busy_latency", n, 28);
        check("busy_bcd", bus.bcd_out, 32'h00000042);
        repeat (40) tick();
        check("busy_pulses", pulses - p0, 1);
        check("busy_hold", bus.bcd_out, 32'h00000042);
        // reset in the middle of a conversion
        p0 = pulses;
        bus.bin_in = 27'd777;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        repeat (9) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_ready", bus.ready_out, 1'b1);
        check("abort_valid", bus.valid_out, 1'b0);
        check("abort_bcd", bus.bcd_out, 32'h0);
        check("abort_ovf", bus.overflow_out, 1'b0);
        repeat (40) tick();
        check("abort_pulses", pulses - p0, 0);
        convert(27'd777, "abort_redo", 32'h00000777, 1'b0);
        // random values against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            v = (i % 3 == 0) ? 27'($urandom_range(134217727, 100000000)) : 27'($urandom_range(99999999, 0));
            convert(v, $sformatf("rnd%0d_%0d", i, v), model_bcd(64'(v)), model_ovf(64'(v)));
        end
        convert(27'd5, "final_clear", 32'h00000005, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Iterative double-dabble converter. Turns an unsigned binary count into DIGITS packed BCD nibbles.
- Sits directly upstream of seven_segment_controller. bcd_out drives its 32-bit val_in, so the display shows decimal.
- Converts one input bit per cycle, uses a ready/valid handshake on input, and holds the last result for display between conversions.

Parameters:
- IN_WIDTH, 27: binary input width. 2^27-1 covers 99_999_999 plus overflow range.
- DIGITS, 8: number of BCD digits. Output width is 4*DIGITS (32 by default).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- bin_in  input  IN_WIDTH  unsigned value to convert; sampled on acceptance
- valid_in  input  1  request; accepted when valid_in && ready_out on a clock edge
- ready_out  output  1  high in IDLE only
- bcd_out  output  4*DIGITS  registered result; nibble k = decimal digit k, nibble 0 = ones
- valid_out  output  1  one-cycle pulse when bcd_out updates
- overflow_out  output  1  registered; result exceeded 10^DIGITS-1 (see Optional Feature)

Behaviour:
- Reset (rst_in high at an edge):
  - state=IDLE, bcd_out=0, valid_out=0, overflow_out=0, internal shift/BCD registers=0.
  - valid_in ignored in any cycle rst_in is high.
- States: IDLE, SHIFT, DONE. ready_out = (state==IDLE), combinational from state.
- IDLE:
  - On acceptance: capture bin_in into shift register, clear working BCD register, load bit counter=IN_WIDTH, go SHIFT.
  - Also latch ovf = (bin_in > 10^DIGITS-1). Compare at width max(IN_WIDTH, ceil(log2(10^DIGITS))).
- SHIFT, each cycle, in this order:
  1. Every working digit >= 5 gets +3.
  2. Shift {BCD, bin} left one bit. The bit leaving the top digit is discarded.
  3. Decrement counter. When it reaches 0 after the shift, go DONE.
  - Exactly IN_WIDTH SHIFT cycles.
- DONE (one cycle):
  - bcd_out <= working BCD register; overflow_out <= ovf (macro-dependent); valid_out=1; next state IDLE.
- Latency and throughput:
  - Acceptance edge = cycle 0. valid_out is high in cycle IN_WIDTH+1; bcd_out is valid from that cycle on.
  - ready_out is low for IN_WIDTH+1 cycles after acceptance.
  - Maximum throughput: one conversion per IN_WIDTH+2 cycles.
- Between conversions:
  - bcd_out and overflow_out hold their last values.
  - valid_out is low except in DONE.
  - bin_in changes after acceptance have no effect.
- valid_in while busy: ignored, not queued. The upstream must hold valid_in until ready_out is seen.
- valid_in held continuously high: accepted in the IDLE cycle immediately after each DONE.
- Reset mid-conversion: aborts. No valid_out pulse; all outputs return to reset values next cycle.
- Overflow without saturation: result is bin_in mod 10^DIGITS, a natural consequence of the discarded carry.
- Every nibble of bcd_out is always 0-9, except when saturated (see Optional Feature).

Optional Feature:
- Macro: BCD_OVERFLOW_SAT_EN.
- Defined:
  - If ovf was latched, DONE loads bcd_out with every nibble = 4'hE, so the display shows "EEEEEEEE".
  - overflow_out is set to 1, and cleared to 0 on the next non-overflow result.
- Undefined:
  - bcd_out takes the mod 10^DIGITS value.
  - overflow_out is tied to 0.
  - No overflow compare logic is synthesised.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset, then bin_in=12_345_678 with one-cycle valid_in -> ready_out low 28 cycles; valid_out single pulse in cycle 28; bcd_out=32'h12345678; overflow_out=0.
- bin_in=0, then bin_in=99_999_999 back-to-back with valid_in held high -> bcd_out=32'h00000000, then 32'h99999999. Second acceptance is the cycle after the first DONE (29-cycle spacing). Exactly two valid_out pulses.
- bin_in=100_000_000 -> with BCD_OVERFLOW_SAT_EN: bcd_out=32'hEEEEEEEE, overflow_out=1. Without: bcd_out=32'h00000000, overflow_out=0.
- bin_in=134_217_727 (all ones) -> with macro: 32'hEEEEEEEE, overflow_out=1. Without: 32'h34217727. Then bin_in=5 -> 32'h00000005, overflow_out=0 in both builds.
- Change bin_in and pulse valid_in during SHIFT of a conversion of 42 -> second request ignored; bcd_out=32'h00000042; only one valid_out pulse.
- Assert rst_in for one cycle at SHIFT cycle 10 of converting 777 -> no valid_out pulse; bcd_out=0; ready_out=1 on the cycle after reset deasserts. A new request for 777 then yields 32'h00000777.
